// File: rtl/mult_eval_sequencer_if.sv
// Bus between the exhaustive multiplier sequencer and its surroundings:
// the multiplier operand/product lines plus the sweep control and verdict.
interface mult_eval_sequencer_if #(
    parameter int WIDTH = 2
);
    // start is taken only while the sequencer is idle (busy low); once taken, busy
    // stays high through the done pulse and results hold until the next accepted start.
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2*WIDTH:0]     err_count;
    logic                 fail_valid;
    logic [WIDTH-1:0]     first_fail_a;
    logic [WIDTH-1:0]     first_fail_b;
    logic [2*WIDTH-1:0]   first_fail_p;
    logic [WIDTH-1:0]     dut_a;
    logic [WIDTH-1:0]     dut_b;
    logic [2*WIDTH-1:0]   dut_p;

    modport master (
        input  start, dut_p,
        output busy, done, pass, err_count, fail_valid,
               first_fail_a, first_fail_b, first_fail_p, dut_a, dut_b
    );

    modport slave (
        output start, dut_p,
        input  busy, done, pass, err_count, fail_valid,
               first_fail_a, first_fail_b, first_fail_p, dut_a, dut_b
    );
endinterface

// File: rtl/mult_eval_sequencer.sv
// Drives every operand pair into a combinational multiplier, samples the product
// after SETTLE cycles and reports an error count plus the first failing vector.
module mult_eval_sequencer #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_eval_sequencer_if.master bus,
    output logic [1:0]            dbg_state
);
    localparam int PW = 2 * WIDTH;
    localparam int EW = PW + 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [PW-1:0] IDX_LAST    = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   idx;
    logic [PW-1:0]   idx_next;
    logic [SW-1:0]   settle_cnt;
    logic [PW-1:0]   ref_p;
    logic            mismatch;
    logic [EW-1:0]   err_inc;

    // Operands are zero-extended first so the reference product loses no bits.
    always_comb begin
        ref_p    = PW'(bus.dut_a) * PW'(bus.dut_b);
        mismatch = (bus.dut_p != ref_p);
        err_inc  = bus.err_count + EW'(mismatch);
        idx_next = idx + PW'(1);
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= '0;
            settle_cnt       <= '0;
            bus.dut_a        <= '0;
            bus.dut_b        <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.pass         <= 1'b0;
            bus.err_count    <= '0;
            bus.fail_valid   <= 1'b0;
            bus.first_fail_a <= '0;
            bus.first_fail_b <= '0;
            bus.first_fail_p <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx              <= '0;
                        settle_cnt       <= '0;
                        bus.dut_a        <= '0;
                        bus.dut_b        <= '0;
                        bus.busy         <= 1'b1;
                        bus.pass         <= 1'b0;
                        bus.err_count    <= '0;
                        bus.fail_valid   <= 1'b0;
                        bus.first_fail_a <= '0;
                        bus.first_fail_b <= '0;
                        bus.first_fail_p <= '0;
                        state            <= APPLY;
                    end
                end
                APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        bus.err_count <= err_inc;
                        if (!bus.fail_valid) begin
                            bus.fail_valid   <= 1'b1;
                            bus.first_fail_a <= bus.dut_a;
                            bus.first_fail_b <= bus.dut_b;
                            bus.first_fail_p <= bus.dut_p;
                        end
                    end
                    // The verdict uses this vector's count so pass is already valid in FIN.
                    if (idx == IDX_LAST) begin
                        bus.done <= 1'b1;
                        bus.pass <= (err_inc == '0);
                        state    <= FIN;
                    end else begin
                        idx       <= idx_next;
                        bus.dut_a <= idx_next[WIDTH-1:0];
                        bus.dut_b <= idx_next[PW-1:WIDTH];
                        state     <= APPLY;
                    end
                end
                FIN: begin
                    bus.done  <= 1'b0;
                    bus.busy  <= 1'b0;
                    bus.dut_a <= '0;
                    bus.dut_b <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_eval_sequencer.sv
// Bench for mult_eval_sequencer: a faultable multiplier model feeds two sequencers
// (SETTLE=1 and SETTLE=3); results are scored against a list of expected mismatches.
module tb_mult_eval_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic start;
    int   sel;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult_eval_sequencer_if #(.WIDTH(2)) i1 ();
    mult_eval_sequencer_if #(.WIDTH(2)) i3 ();
    logic [1:0] st1;
    logic [1:0] st3;

    mult_eval_sequencer #(.WIDTH(2), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(i1.master), .dbg_state(st1)
    );
    mult_eval_sequencer #(.WIDTH(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .bus(i3.master), .dbg_state(st3)
    );

    // Multiplier under evaluation: correct unless a vector is marked faulty.
    logic       bad_en [16];
    logic [3:0] bad_p  [16];

    always_comb begin
        i1.start = start && (sel == 0);
        i3.start = start && (sel == 1);
        i1.dut_p = bad_en[{i1.dut_b, i1.dut_a}] ? bad_p[{i1.dut_b, i1.dut_a}]
                                                : {2'b00, i1.dut_a} * {2'b00, i1.dut_b};
        i3.dut_p = bad_en[{i3.dut_b, i3.dut_a}] ? bad_p[{i3.dut_b, i3.dut_a}]
                                                : {2'b00, i3.dut_a} * {2'b00, i3.dut_b};
    end

    logic        s_busy, s_done;
    logic [1:0]  s_a, s_b;
    logic [14:0] s_res;
    logic [14:0] r1_all, r3_all;

    always_comb begin
        r1_all = {i1.pass, i1.fail_valid, i1.err_count, i1.first_fail_a, i1.first_fail_b, i1.first_fail_p};
        r3_all = {i3.pass, i3.fail_valid, i3.err_count, i3.first_fail_a, i3.first_fail_b, i3.first_fail_p};
        s_busy = (sel == 0) ? i1.busy  : i3.busy;
        s_done = (sel == 0) ? i1.done  : i3.done;
        s_a    = (sel == 0) ? i1.dut_a : i3.dut_a;
        s_b    = (sel == 0) ? i1.dut_b : i3.dut_b;
        s_res  = (sel == 0) ? r1_all   : r3_all;
    end

    // Scoreboard: expected mismatching vectors in sweep order, each {a, b, p}.
    logic [7:0] exp_q[$];
    logic [1:0] seen_a [0:80];
    logic [1:0] seen_b [0:80];

    function automatic void build_model();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            int a;
            int b;
            int p;
            a = i % 4;
            b = i / 4;
            p = bad_en[i] ? int'(bad_p[i]) : a * b;
            if (p != a * b) exp_q.push_back({2'(a), 2'(b), 4'(p)});
        end
    endfunction

    function automatic logic [14:0] exp_res();
        if (exp_q.size() == 0) return {1'b1, 1'b0, 5'd0, 8'd0};
        return {1'b0, 1'b1, 5'(exp_q.size()), exp_q[0]};
    endfunction

    function automatic void clear_faults();
        for (int i = 0; i < 16; i++) begin
            bad_en[i] = 1'b0;
            bad_p[i]  = 4'd0;
        end
    endfunction

    task automatic run_sweep(input int exp_done, output int done_cyc, output int busy_hi,
                             output int done_cnt);
        done_cyc = -1;
        busy_hi  = 0;
        done_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= exp_done + 3; c++) begin
            @(negedge clk);
            if (s_busy) busy_hi++;
            if (s_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c <= 80) begin
                seen_a[c] = s_a;
                seen_b[c] = s_b;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        sel   = 0;
        clear_faults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (r1_all !== 15'd0 || {i1.busy, i1.done, i1.dut_a, i1.dut_b} !== 6'd0) begin
            errors++;
            $display("FAIL reset_s1: results=%h ctl=%b required 0", r1_all,
                     {i1.busy, i1.done, i1.dut_a, i1.dut_b});
        end
        checks++;
        if (r3_all !== 15'd0 || {i3.busy, i3.done, i3.dut_a, i3.dut_b} !== 6'd0) begin
            errors++;
            $display("FAIL reset_s3: results=%h ctl=%b required 0", r3_all,
                     {i3.busy, i3.done, i3.dut_a, i3.dut_b});
        end
        checks++;
        if (st1 !== 2'd0 || st3 !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d/%0d required 0/0", st1, st3);
        end
        rst = 1'b0;
    endtask

    task automatic test_correct();
        int dc, bh, dn;
        sel = 0;
        clear_faults();
        build_model();
        run_sweep(33, dc, bh, dn);
        checks++;
        if (dc != 33 || dn != 1) begin
            errors++;
            $display("FAIL correct_done: cycle=%0d pulses=%0d required 33/1", dc, dn);
        end
        checks++;
        if (bh != 33 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL correct_busy: high_cycles=%0d busy_now=%b required 33/0", bh, s_busy);
        end
        checks++;
        if (s_res !== exp_res()) begin
            errors++;
            $display("FAIL correct_result: got %h required %h", s_res, exp_res());
        end
    endtask

    task automatic test_stuck_zero();
        int dc, bh, dn;
        sel = 0;
        for (int i = 0; i < 16; i++) begin
            bad_en[i] = 1'b1;
            bad_p[i]  = 4'd0;
        end
        build_model();
        run_sweep(33, dc, bh, dn);
        checks++;
        if (s_res !== exp_res()) begin
            errors++;
            $display("FAIL stuck_zero_model: got %h required %h", s_res, exp_res());
        end
        checks++;
        if (s_res !== {1'b0, 1'b1, 5'd9, 2'd1, 2'd1, 4'd0}) begin
            errors++;
            $display("FAIL stuck_zero_spec: got %h required err 9 first a1 b1 p0", s_res);
        end
    endtask

    task automatic test_three_by_three();
        int dc, bh, dn;
        sel = 0;
        clear_faults();
        bad_en[15] = 1'b1;
        bad_p[15]  = 4'd8;
        build_model();
        run_sweep(33, dc, bh, dn);
        checks++;
        if (s_res !== exp_res() || s_res !== {1'b0, 1'b1, 5'd1, 2'd3, 2'd3, 4'd8}) begin
            errors++;
            $display("FAIL three_by_three: got %h required %h", s_res, exp_res());
        end
        checks++;
        if (dc != 33) begin
            errors++;
            $display("FAIL three_by_three_done: cycle=%0d required 33", dc);
        end
    endtask

    task automatic test_random_faults(input int which, input int iters);
        int dc, bh, dn, exp_done;
        sel      = which;
        exp_done = (which == 0) ? 33 : 65;
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < 16; i++) begin
                bad_en[i] = ($urandom_range(0, 3) == 0);
                bad_p[i]  = 4'($urandom_range(0, 15));
            end
            build_model();
            run_sweep(exp_done, dc, bh, dn);
            checks++;
            if (s_res !== exp_res() || dc != exp_done) begin
                errors++;
                $display("FAIL random_s%0d_%0d: got %h done %0d required %h done %0d",
                         which, it, s_res, dc, exp_res(), exp_done);
            end
        end
    endtask

    task automatic test_rst_mid_sweep();
        int dc, bh, dn, late_done;
        sel = 0;
        for (int i = 0; i < 16; i++) begin
            bad_en[i] = 1'b1;
            bad_p[i]  = 4'd15;
        end
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 9) begin
                checks++;
                if (s_res[13] !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_sweep_failvalid: got %b required 1", s_res[13]);
                end
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({s_res, s_busy, s_done, s_a, s_b} !== 21'd0 || st1 !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h state %0d required 0",
                     {s_res, s_busy, s_done, s_a, s_b}, st1);
        end
        late_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (s_done || s_busy) late_done++;
        end
        checks++;
        if (late_done != 0) begin
            errors++;
            $display("FAIL rst_mid_no_done: active_cycles=%0d required 0", late_done);
        end
        clear_faults();
        build_model();
        run_sweep(33, dc, bh, dn);
        checks++;
        if (dc != 33 || s_res !== exp_res()) begin
            errors++;
            $display("FAIL rst_mid_restart: done %0d res %h required 33 %h", dc, s_res, exp_res());
        end
    endtask

    task automatic test_back_to_back();
        int busy_bad, done_bad;
        logic exp_busy, exp_done;
        sel = 0;
        clear_faults();
        build_model();
        busy_bad = 0;
        done_bad = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            // First sweep: cycles 1..33; IDLE at 34 takes start; second sweep 35..67.
            exp_busy = (c <= 33) || (c >= 35 && c <= 67);
            exp_done = (c == 33) || (c == 67);
            if (s_busy !== exp_busy) busy_bad++;
            if (s_done !== exp_done) done_bad++;
            if (c == 35) start = 1'b0;
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL b2b_busy: wrong_cycles=%0d required 0", busy_bad);
        end
        checks++;
        if (done_bad != 0) begin
            errors++;
            $display("FAIL b2b_done: wrong_cycles=%0d required 0", done_bad);
        end
        checks++;
        if (s_res !== exp_res()) begin
            errors++;
            $display("FAIL b2b_result: got %h required %h", s_res, exp_res());
        end
    endtask

    task automatic test_rst_start_idle();
        sel = 0;
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checks++;
        if (s_busy !== 1'b0 || st1 !== 2'd0) begin
            errors++;
            $display("FAIL rst_start_idle: busy=%b state=%0d required 0/0", s_busy, st1);
        end
        @(negedge clk);
        checks++;
        if (s_busy !== 1'b0 || st1 !== 2'd0) begin
            errors++;
            $display("FAIL rst_start_idle_next: busy=%b state=%0d required 0/0", s_busy, st1);
        end
    endtask

    task automatic test_settle3();
        int dc, bh, dn, op_bad;
        sel = 1;
        clear_faults();
        build_model();
        run_sweep(65, dc, bh, dn);
        checks++;
        if (dc != 65 || dn != 1 || bh != 65) begin
            errors++;
            $display("FAIL settle3_timing: done %0d pulses %0d busy %0d required 65/1/65", dc, dn, bh);
        end
        checks++;
        if (s_res !== exp_res()) begin
            errors++;
            $display("FAIL settle3_result: got %h required %h", s_res, exp_res());
        end
        op_bad = 0;
        for (int v = 0; v < 16; v++) begin
            for (int k = 0; k < 4; k++) begin
                if (seen_a[1 + v * 4 + k] !== 2'(v % 4) || seen_b[1 + v * 4 + k] !== 2'(v / 4))
                    op_bad++;
            end
        end
        checks++;
        if (op_bad != 0) begin
            errors++;
            $display("FAIL settle3_operands: unstable_cycles=%0d required 0", op_bad);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck_zero();
        test_three_by_three();
        test_random_faults(0, 8);
        test_rst_mid_sweep();
        test_back_to_back();
        test_rst_start_idle();
        test_settle3();
        test_random_faults(1, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
